// File: rtl/spec_cfg_pkg.sv
// Shared constants for the config loader: FSM encodings, default bus width and
// helpers that size the word array and the valid bits of the top word.
package spec_cfg_pkg;

  localparam int DEFAULT_WORD_WIDTH = 32;

  localparam logic [1:0] ST_EMPTY   = 2'd0;
  localparam logic [1:0] ST_LOADING = 2'd1;
  localparam logic [1:0] ST_ACTIVE  = 2'd2;

  function automatic int calc_num_words(input int mem_bits, input int word_bits);
    return (mem_bits + word_bits - 1) / word_bits;
  endfunction

  // Number of meaningful bits in the highest word; the rest are discarded on write.
  function automatic int calc_last_bits(input int mem_bits, input int word_bits);
    return mem_bits - (calc_num_words(mem_bits, word_bits) - 1) * word_bits;
  endfunction

endpackage

// File: rtl/spec_cfg_shadow_regs.sv
// Word-addressed shadow image plus written-bitmap, with a one-cycle read port.
// Clear wipes words and bitmap but a concurrent read still answers (with zero).
module spec_cfg_shadow_regs
  import spec_cfg_pkg::*;
#(
  parameter int CONFIG_MEMORY_SIZE = 512,
  parameter int WORD_WIDTH         = DEFAULT_WORD_WIDTH,
  parameter int NUM_WORDS          = calc_num_words(CONFIG_MEMORY_SIZE, WORD_WIDTH),
  parameter int AW                 = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear,
  input  logic                          wr_en,
  input  logic                          rd_en,
  input  logic                          in_range,
  input  logic [AW-1:0]                 idx,
  input  logic [WORD_WIDTH-1:0]         wr_data,
  output logic [WORD_WIDTH-1:0]         rd_data,
  output logic                          rd_valid,
  output logic [CONFIG_MEMORY_SIZE-1:0] image,
  output logic                          bitmap_full
);

  localparam int LAST_BITS = calc_last_bits(CONFIG_MEMORY_SIZE, WORD_WIDTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_WORDS - 1);
  localparam logic [WORD_WIDTH-1:0] LAST_MASK = {WORD_WIDTH{1'b1}} >> (WORD_WIDTH - LAST_BITS);

  logic [WORD_WIDTH-1:0] words [NUM_WORDS];
  logic [NUM_WORDS-1:0]  bitmap;
  logic [WORD_WIDTH-1:0] wr_mask;

  assign wr_mask     = (idx == LAST_IDX) ? LAST_MASK : {WORD_WIDTH{1'b1}};
  assign bitmap_full = &bitmap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_WORDS; i++) words[i] <= '0;
      bitmap   <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      // Read samples the pre-write word, so a same-cycle write is not visible.
      if (rd_en) rd_data <= (clear || !in_range) ? '0 : words[idx];
      if (clear) begin
        for (int i = 0; i < NUM_WORDS; i++) words[i] <= '0;
        bitmap <= '0;
      end else if (wr_en && in_range) begin
        words[idx]  <= wr_data & wr_mask;
        bitmap[idx] <= 1'b1;
      end
    end
  end

  for (genvar w = 0; w < NUM_WORDS - 1; w++) begin : g_img
    assign image[w*WORD_WIDTH +: WORD_WIDTH] = words[w];
  end
  assign image[CONFIG_MEMORY_SIZE-1:(NUM_WORDS-1)*WORD_WIDTH] = words[NUM_WORDS-1][LAST_BITS-1:0];

endmodule

// File: rtl/spec_config_loader.sv
// Config front-end for lakespec: assembles a shadow image from word writes and
// copies it atomically to config_memory on a commit with every word written.
module spec_config_loader
  import spec_cfg_pkg::*;
#(
  parameter int CONFIG_MEMORY_SIZE = 512,
  parameter int WORD_WIDTH         = DEFAULT_WORD_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [31:0]                   config_addr,
  input  logic [WORD_WIDTH-1:0]         config_data,
  input  logic                          config_write,
  input  logic                          config_read,
  input  logic                          config_commit,
  input  logic                          config_clear,
  output logic [WORD_WIDTH-1:0]         config_rd_data,
  output logic                          config_rd_valid,
  output logic [CONFIG_MEMORY_SIZE-1:0] config_memory,
  output logic                          config_valid,
  output logic                          load_done,
  output logic                          commit_error,
  output logic                          addr_error
);

  localparam int NUM_WORDS = calc_num_words(CONFIG_MEMORY_SIZE, WORD_WIDTH);
  localparam int AW        = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  logic [1:0]                    state;
  logic                          in_range;
  logic                          bitmap_full;
  logic                          commit_ok;
  logic [CONFIG_MEMORY_SIZE-1:0] shadow_image;

  assign in_range  = config_addr < 32'(NUM_WORDS);
  // Both the copy and the completeness check use pre-write shadow contents.
  assign commit_ok = config_commit && bitmap_full;

  spec_cfg_shadow_regs #(
    .CONFIG_MEMORY_SIZE(CONFIG_MEMORY_SIZE),
    .WORD_WIDTH        (WORD_WIDTH)
  ) u_shadow (
    .clk        (clk),
    .rst        (rst),
    .clear      (config_clear),
    .wr_en      (config_write),
    .rd_en      (config_read),
    .in_range   (in_range),
    .idx        (config_addr[AW-1:0]),
    .wr_data    (config_data),
    .rd_data    (config_rd_data),
    .rd_valid   (config_rd_valid),
    .image      (shadow_image),
    .bitmap_full(bitmap_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_EMPTY;
      config_memory <= '0;
      config_valid  <= 1'b0;
      load_done     <= 1'b0;
      commit_error  <= 1'b0;
      addr_error    <= 1'b0;
    end else if (config_clear) begin
      state         <= ST_EMPTY;
      config_memory <= '0;
      config_valid  <= 1'b0;
      load_done     <= 1'b0;
      commit_error  <= 1'b0;
      addr_error    <= 1'b0;
    end else begin
      load_done <= commit_ok;
      if (commit_ok) begin
        config_memory <= shadow_image;
        config_valid  <= 1'b1;
      end
      if (config_commit && !bitmap_full) commit_error <= 1'b1;
      if ((config_write || config_read) && !in_range) addr_error <= 1'b1;
      // A landing write leaves shadow ahead of active, even if a commit also fired.
      if (config_write && in_range)  state <= ST_LOADING;
      else if (commit_ok)            state <= ST_ACTIVE;
    end
  end

endmodule

// File: tb/tb_spec_config_loader.sv
// Directed bench: reads are scoreboarded by a monitor; status outputs are
// compared against hand-computed values after each operation.
module tb_spec_config_loader;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  config_addr, config_data, config_rd_data;
  logic         config_write, config_read, config_commit, config_clear;
  logic         config_rd_valid, config_valid, load_done, commit_error, addr_error;
  logic [511:0] config_memory;

  logic [31:0]  b_addr, b_data, b_rd_data;
  logic         b_write, b_read, b_rd_valid, b_valid, b_done, b_cerr, b_aerr;
  logic [499:0] b_memory;

  int pass_cnt = 0;
  int total    = 0;
  logic [31:0] exp_rd[$];
  logic [31:0] b_exp_rd[$];
  logic [511:0] img;

  always #5 clk = ~clk;

  spec_config_loader dut (
    .clk(clk), .rst(rst), .config_addr(config_addr), .config_data(config_data),
    .config_write(config_write), .config_read(config_read), .config_commit(config_commit),
    .config_clear(config_clear), .config_rd_data(config_rd_data),
    .config_rd_valid(config_rd_valid), .config_memory(config_memory),
    .config_valid(config_valid), .load_done(load_done), .commit_error(commit_error),
    .addr_error(addr_error)
  );

  spec_config_loader #(.CONFIG_MEMORY_SIZE(500)) dut500 (
    .clk(clk), .rst(rst), .config_addr(b_addr), .config_data(b_data),
    .config_write(b_write), .config_read(b_read), .config_commit(1'b0),
    .config_clear(1'b0), .config_rd_data(b_rd_data), .config_rd_valid(b_rd_valid),
    .config_memory(b_memory), .config_valid(b_valid), .load_done(b_done),
    .commit_error(b_cerr), .addr_error(b_aerr)
  );

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (!rst && config_rd_valid) begin
      if (exp_rd.size() == 0) begin
        total++;
        $display("FAIL rd_unexpected: got rd_valid=1 data %0h expected no read", config_rd_data);
      end else chk("rd_data", config_rd_data, exp_rd.pop_front());
    end
    if (!rst && b_rd_valid) begin
      if (b_exp_rd.size() == 0) begin
        total++;
        $display("FAIL b_rd_unexpected: got rd_valid=1 data %0h expected no read", b_rd_data);
      end else chk("b_rd_data", b_rd_data, b_exp_rd.pop_front());
    end
  end

  task automatic op(input logic w, input logic r, input logic c, input logic cl,
                    input logic [31:0] a, input logic [31:0] d);
    config_write = w; config_read = r; config_commit = c; config_clear = cl;
    config_addr = a; config_data = d;
    @(negedge clk);
    config_write = 1'b0; config_read = 1'b0; config_commit = 1'b0; config_clear = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    op(1'b1, 1'b0, 1'b0, 1'b0, a, d);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e);
    exp_rd.push_back(e);
    op(1'b0, 1'b1, 1'b0, 1'b0, a, 32'h0);
  endtask

  task automatic commit();
    op(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    config_addr = '0; config_data = '0;
    config_write = 0; config_read = 0; config_commit = 0; config_clear = 0;
    b_addr = '0; b_data = '0; b_write = 0; b_read = 0;
    #12;
    chk("rst_memory", config_memory, 512'h0);
    chk("rst_valid", config_valid, 0);
    chk("rst_done", load_done, 0);
    chk("rst_cerr", commit_error, 0);
    chk("rst_aerr", addr_error, 0);
    chk("rst_rdv", config_rd_valid, 0);
    @(negedge clk);
    rst = 1'b0;

    // Full load then commit
    img = '0;
    for (int i = 0; i < 16; i++) begin
      wr(i, 32'h1000_0000 + i);
      img[i*32 +: 32] = 32'h1000_0000 + i;
    end
    chk("pre_commit_valid", config_valid, 0);
    commit();
    chk("full_done", load_done, 1);
    chk("full_valid", config_valid, 1);
    chk("full_w0", config_memory[31:0], 32'h1000_0000);
    chk("full_w15", config_memory[511:480], 32'h1000_000F);
    chk("full_img", config_memory, img);
    chk("full_state", dut.state, 2'd2);
    op(0, 0, 0, 0, 0, 0);
    chk("done_one_cycle", load_done, 0);

    // Shadow isolation
    wr(3, 32'hDEAD_BEEF);
    chk("iso_w3", config_memory[127:96], 32'h1000_0003);
    chk("iso_state", dut.state, 2'd1);
    chk("iso_valid", config_valid, 1);
    rd(3, 32'hDEAD_BEEF);
    commit();
    chk("iso_commit_w3", config_memory[127:96], 32'hDEAD_BEEF);
    chk("iso_commit_state", dut.state, 2'd2);

    // Same-cycle write and commit
    op(1'b1, 1'b0, 1'b1, 1'b0, 0, 32'h5555_5555);
    chk("wc_w0_old", config_memory[31:0], 32'h1000_0000);
    chk("wc_done", load_done, 1);
    chk("wc_state", dut.state, 2'd1);
    rd(0, 32'h5555_5555);
    commit();
    chk("wc_recommit_w0", config_memory[31:0], 32'h5555_5555);

    // Same-cycle read and write to one address returns old data
    exp_rd.push_back(32'h1000_0001);
    op(1'b1, 1'b1, 1'b0, 1'b0, 1, 32'hAAAA_AAAA);
    rd(1, 32'hAAAA_AAAA);

    // Out of range
    chk("oor_aerr_before", addr_error, 0);
    wr(16, 32'hFFFF_FFFF);
    chk("oor_aerr_wr", addr_error, 1);
    chk("oor_state", dut.state, 2'd1);
    rd(40, 32'h0);
    rd(15, 32'h1000_000F);
    rd(0, 32'h5555_5555);

    // Clear beats commit and write; concurrent read yields zero
    exp_rd.push_back(32'h0);
    op(1'b1, 1'b1, 1'b1, 1'b1, 2, 32'h1234_5678);
    chk("clr_memory", config_memory, 512'h0);
    chk("clr_valid", config_valid, 0);
    chk("clr_done", load_done, 0);
    chk("clr_aerr", addr_error, 0);
    chk("clr_state", dut.state, 2'd0);
    rd(2, 32'h0);
    rd(15, 32'h0);

    // Incomplete load is rejected
    img = '0;
    for (int i = 0; i < 15; i++) begin
      wr(i, 32'h2000_0000 + i);
      img[i*32 +: 32] = 32'h2000_0000 + i;
    end
    commit();
    chk("inc_cerr", commit_error, 1);
    chk("inc_valid", config_valid, 0);
    chk("inc_memory", config_memory, 512'h0);
    chk("inc_done", load_done, 0);
    chk("inc_state", dut.state, 2'd1);
    wr(15, 32'h2000_000F);
    img[511:480] = 32'h2000_000F;
    commit();
    chk("inc2_done", load_done, 1);
    chk("inc2_cerr_sticky", commit_error, 1);
    chk("inc2_img", config_memory, img);
    op(0, 0, 0, 0, 0, 0);
    commit();
    chk("recommit_done", load_done, 1);
    chk("recommit_img", config_memory, img);

    // Partial top word on the 500-bit instance
    b_write = 1; b_addr = 15; b_data = 32'hFFFF_FFFF;
    @(negedge clk);
    b_addr = 0; b_data = 32'hCAFE_F00D;
    @(negedge clk);
    b_write = 0; b_read = 1; b_addr = 15;
    b_exp_rd.push_back(32'h000F_FFFF);
    @(negedge clk);
    b_addr = 0;
    b_exp_rd.push_back(32'hCAFE_F00D);
    @(negedge clk);
    b_read = 0;
    @(negedge clk);

    // Async reset mid-load
    wr(4, 32'h7777_7777);
    wr(5, 32'h8888_8888);
    rst = 1'b1;
    #1;
    chk("arst_memory", config_memory, 512'h0);
    chk("arst_valid", config_valid, 0);
    chk("arst_cerr", commit_error, 0);
    chk("arst_state", dut.state, 2'd0);
    @(negedge clk);
    rst = 1'b0;
    commit();
    chk("arst_commit_rejected", commit_error, 1);
    chk("arst_commit_memory", config_memory, 512'h0);

    @(negedge clk);
    chk("rd_queue_drained", exp_rd.size() + b_exp_rd.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/spec_config_loader.md
Name: spec_config_loader

Overview:
- Configuration front-end that sits directly upstream of lakespec and drives its config_memory input.
- Accepts 32-bit word writes and reads on a simple config bus, assembling them into a shadow image of CONFIG_MEMORY_SIZE bits.
- On an accepted commit, the complete shadow image is transferred atomically to the active config_memory output.
- lakespec never sees a partially written configuration.

Parameters:
- CONFIG_MEMORY_SIZE, 512, width in bits of the active/shadow configuration image.
- WORD_WIDTH, 32, config bus data width.
- NUM_WORDS, ceil(CONFIG_MEMORY_SIZE/WORD_WIDTH) (derived, localparam), number of addressable words.

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- config_addr  in  32  word address (word 0 = bits [31:0])
- config_data  in  WORD_WIDTH  write data
- config_write  in  1  write strobe, one word per cycle high
- config_read  in  1  read strobe
- config_commit  in  1  request shadow->active transfer
- config_clear  in  1  synchronous clear of shadow, active, bitmap and state
- config_rd_data  out  WORD_WIDTH  shadow word read data
- config_rd_valid  out  1  read data valid
- config_memory  out  CONFIG_MEMORY_SIZE  active image to lakespec
- config_valid  out  1  active image holds a committed configuration
- load_done  out  1  one-cycle pulse on accepted commit
- commit_error  out  1  sticky: commit rejected
- addr_error  out  1  sticky: access with config_addr >= NUM_WORDS

Behaviour:
- Reset (async assert): all outputs 0, shadow 0, written-bitmap 0, state EMPTY.
- States:
  - EMPTY: no commit since reset/clear; config_valid=0.
  - LOADING: shadow differs from active because writes occurred since the last commit.
  - ACTIVE: active == shadow; config_valid=1.
- config_valid stays 1 in LOADING once any commit has been accepted.
- Write handling:
  - A write with addr < NUM_WORDS updates shadow word addr at the clock edge and sets bitmap[addr].
  - The state moves EMPTY->LOADING or ACTIVE->LOADING.
- Partial top word:
  - When CONFIG_MEMORY_SIZE is not a multiple of WORD_WIDTH, the upper bits of the last word are discarded on write.
  - Those discarded bits read back as 0.
- Read handling:
  - A read with addr < NUM_WORDS returns the shadow word on config_rd_data with config_rd_valid=1 the next cycle (latency 1).
  - config_rd_valid is 0 on every cycle not following a read.
  - config_rd_data holds its last value when config_rd_valid=0.
- Out-of-range access (read or write, addr >= NUM_WORDS):
  - No state change.
  - addr_error set sticky.
  - A read still returns config_rd_valid=1 with data 0.
- Commit with all NUM_WORDS bitmap bits set:
  - Next edge: config_memory <= shadow, config_valid=1, load_done=1 for exactly one cycle, state -> ACTIVE.
- Commit with an incomplete bitmap:
  - Rejected: commit_error set sticky.
  - config_memory and state are unchanged, and load_done stays 0.
- Bitmap is cleared only by rst or config_clear. Partial rewrites after a first full load may therefore be committed.
- Commit in EMPTY with a full bitmap is legal. Commit in ACTIVE re-commits the identical image: load_done pulses and config_memory is unchanged.
- Simultaneous write and commit in the same cycle:
  - The commit copies the pre-write shadow, and the bitmap check uses the pre-write bitmap.
  - The write lands in shadow only, and the final state is LOADING.
- Simultaneous read and write to the same address: the read returns pre-write data.
- config_clear has priority over all other inputs in that cycle:
  - Shadow, active, bitmap, config_valid, commit_error and addr_error are zeroed; state -> EMPTY.
  - A concurrent read still responds next cycle, with data 0.
- Reset mid-load: everything returns to reset values immediately. No partial image reaches config_memory.

Decomposition:
- Shared package spec_cfg_pkg holds:
  - the state enum (EMPTY, LOADING, ACTIVE);
  - the WORD_WIDTH default;
  - a function computing NUM_WORDS and the last-word valid-bit mask.
- One natural sub-module, spec_cfg_shadow_regs: a word-addressed shadow register file plus written-bitmap with a synchronous read port.
- The top level holds the FSM, the active register and the error flags.

Test Plan:
- Full load, then commit:
  - Stimulus: write words 0..15 with data 32'h1000_0000+i, then pulse commit.
  - Response one cycle later: load_done=1 for one cycle, config_valid=1, config_memory[31:0]=32'h1000_0000, config_memory[511:480]=32'h1000_000F.
- Incomplete commit:
  - Stimulus: write words 0..14 only, then pulse commit.
  - Response: commit_error=1, config_valid=0, config_memory=0, load_done never pulses.
  - Then write word 15 and commit again: accepted, commit_error stays 1 (sticky).
- Shadow isolation:
  - Stimulus: after a full commit, write word 3=32'hDEAD_BEEF.
  - Response: config_memory[127:96] unchanged and state LOADING.
  - Read of addr 3 the next cycle returns 32'hDEAD_BEEF with config_rd_valid=1.
  - A following commit updates config_memory[127:96].
- Same-cycle write+commit:
  - Stimulus: with a full bitmap, write word 0=32'h5555_5555 together with commit.
  - Response: config_memory[31:0] keeps its old value, load_done=1, and shadow word 0 reads back 32'h5555_5555.
- Out-of-range address:
  - Stimulus: write addr 16, then read addr 40.
  - Response: addr_error=1, shadow unchanged, and the read gives rd_valid=1 with data 0.
  - With CONFIG_MEMORY_SIZE=500, a write of word 15=32'hFFFF_FFFF reads back 32'h000F_FFFF.
- Clear and reset priority:
  - config_clear together with commit and write: everything zeroed, state EMPTY, load_done=0.
  - Async rst asserted mid-load: all outputs 0 before the next clk edge.
